// File: rtl/rv_pkg.sv
// Shared register-file types and widths for the writeback path.
package rv_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;
    localparam int NUM_REGS   = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       wd;
    } rf_wr_t;

    typedef enum logic {
        PIPE_PRI = 1'b0,
        LL_FORCE = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-destination scoreboard for long-latency ops, with hazard query.
module rf_scoreboard
    import rv_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  set_en,
    input  logic [REG_ADDR_W-1:0] set_rd,
    input  logic                  clr_en,
    input  logic [REG_ADDR_W-1:0] clr_rd,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    output logic [NUM_REGS-1:0]   busy_mask,
    output logic                  hz_stall
);

    logic [NUM_REGS-1:0] busy_next;

    // Set is applied after clear: a same-cycle reservation belongs to a newer op.
    always_comb begin
        busy_next = busy_mask;
        if (clr_en) busy_next[clr_rd] = 1'b0;
        if (set_en) busy_next[set_rd] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_mask <= '0;
        else        busy_mask <= busy_next;
    end

    always_comb begin
        hz_stall = ((rs1 != '0) && busy_mask[rs1]) ||
                   ((rs2 != '0) && busy_mask[rs2]);
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates the register file write port between writeback and a long-latency unit.
module rf_write_arbiter
    import rv_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pipe_valid,
    output logic                  pipe_ready,
    input  logic [REG_ADDR_W-1:0] pipe_rd,
    input  logic [XLEN-1:0]       pipe_wd,
    input  logic                  ll_valid,
    output logic                  ll_ready,
    input  logic [REG_ADDR_W-1:0] ll_rd,
    input  logic [XLEN-1:0]       ll_wd,
    input  logic                  rsv_valid,
    input  logic [REG_ADDR_W-1:0] rsv_rd,
    input  logic [REG_ADDR_W-1:0] hz_rs1,
    input  logic [REG_ADDR_W-1:0] hz_rs2,
    output logic                  hz_stall,
    output logic [NUM_REGS-1:0]   busy_mask,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_rd,
    output logic [XLEN-1:0]       rf_wd
);

    localparam logic [3:0] LIMIT    = 4'(STARVE_LIMIT);
    localparam logic [3:0] LIMIT_M1 = 4'(STARVE_LIMIT - 1);

    arb_state_e state;
    logic [3:0] wait_cnt;
    logic       pipe_xfer, ll_xfer, ll_refused;

    always_comb begin
        pipe_ready = (state == PIPE_PRI);
        ll_ready   = (state == LL_FORCE) || !pipe_valid;
        pipe_xfer  = pipe_valid && pipe_ready;
        ll_xfer    = ll_valid && ll_ready;
        ll_refused = ll_valid && !ll_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= PIPE_PRI;
            wait_cnt <= '0;
            rf_we    <= 1'b0;
            rf_rd    <= '0;
            rf_wd    <= '0;
        end else begin
            if (ll_xfer)
                wait_cnt <= '0;
            else if (ll_refused && wait_cnt != LIMIT)
                wait_cnt <= wait_cnt + 4'd1;

            case (state)
                PIPE_PRI: if (ll_refused && wait_cnt == LIMIT_M1) state <= LL_FORCE;
                LL_FORCE: if (ll_xfer) state <= PIPE_PRI;
                default:  state <= PIPE_PRI;
            endcase

            // At most one side can transfer in a cycle given the ready logic.
            if (pipe_xfer) begin
                rf_we <= (pipe_rd != '0);
                rf_rd <= pipe_rd;
                rf_wd <= pipe_wd;
            end else if (ll_xfer) begin
                rf_we <= (ll_rd != '0);
                rf_rd <= ll_rd;
                rf_wd <= ll_wd;
            end else begin
                rf_we <= 1'b0;
            end
        end
    end

    rf_scoreboard u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .set_en    (rsv_valid),
        .set_rd    (rsv_rd),
        .clr_en    (ll_xfer),
        .clr_rd    (ll_rd),
        .rs1       (hz_rs1),
        .rs2       (hz_rs2),
        .busy_mask (busy_mask),
        .hz_stall  (hz_stall)
    );

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scenario bench for rf_write_arbiter with a queue of expected register file writes.
module tb_rf_write_arbiter;
    import rv_pkg::*;

    localparam int STARVE_LIMIT = 4;

    logic        clk, rst_n;
    logic        pipe_valid, pipe_ready;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_wd;
    logic        ll_valid, ll_ready;
    logic [4:0]  ll_rd;
    logic [31:0] ll_wd;
    logic        rsv_valid;
    logic [4:0]  rsv_rd, hz_rs1, hz_rs2;
    logic        hz_stall;
    logic [31:0] busy_mask;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wd;

    int n_cmp = 0;
    int n_err = 0;
    rf_wr_t exp_q[$];

    rf_write_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .pipe_valid(pipe_valid), .pipe_ready(pipe_ready), .pipe_rd(pipe_rd), .pipe_wd(pipe_wd),
        .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_rd(ll_rd), .ll_wd(ll_wd),
        .rsv_valid(rsv_valid), .rsv_rd(rsv_rd), .hz_rs1(hz_rs1), .hz_rs2(hz_rs2),
        .hz_stall(hz_stall), .busy_mask(busy_mask),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wd(rf_wd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each write accepted before an edge must appear on rf_* right after that edge.
    always @(posedge clk) begin
        rf_wr_t e;
        #1;
        if (rst_n) begin
            n_cmp++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (rf_we !== 1'b1 || rf_rd !== e.rd || rf_wd !== e.wd) begin
                    n_err++;
                    $display("FAIL rf_write: got we=%b rd=%0d wd=%h, required we=1 rd=%0d wd=%h",
                             rf_we, rf_rd, rf_wd, e.rd, e.wd);
                end
            end else if (rf_we !== 1'b0) begin
                n_err++;
                $display("FAIL rf_idle: got we=%b rd=%0d, required we=0", rf_we, rf_rd);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        pipe_valid = 0; pipe_rd = 0; pipe_wd = 0;
        ll_valid = 0; ll_rd = 0; ll_wd = 0;
        rsv_valid = 0; rsv_rd = 0; hz_rs1 = 0; hz_rs2 = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle_inputs();
        #1;
        n_cmp++;
        if (rf_we !== 0 || rf_rd !== 0 || rf_wd !== 0 || busy_mask !== 0) begin
            n_err++;
            $display("FAIL reset_regs: we=%b rd=%0d wd=%h busy=%h, required all 0", rf_we, rf_rd, rf_wd, busy_mask);
        end
        n_cmp++;
        if (pipe_ready !== 1 || ll_ready !== 1) begin
            n_err++;
            $display("FAIL reset_ready_idle: pipe_ready=%b ll_ready=%b, required 1/1", pipe_ready, ll_ready);
        end
        pipe_valid = 1;
        #1;
        n_cmp++;
        if (ll_ready !== 0) begin
            n_err++;
            $display("FAIL reset_ll_ready: ll_ready=%b, required 0", ll_ready);
        end
        pipe_valid = 0;
        @(negedge clk); @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_pipe_only();
        pipe_valid = 1; pipe_rd = 5; pipe_wd = 32'hDEADBEEF;
        #1;
        n_cmp++;
        if (pipe_ready !== 1) begin
            n_err++;
            $display("FAIL pipe_ready: got %b, required 1", pipe_ready);
        end
        exp_q.push_back(rf_wr_t'{5'd5, 32'hDEADBEEF});
        @(negedge clk);
        pipe_valid = 0;
        @(negedge clk);
    endtask

    task automatic test_contention();
        pipe_valid = 1; pipe_rd = 3; ll_valid = 1; ll_rd = 7; ll_wd = 32'h1234;
        for (int c = 1; c <= STARVE_LIMIT; c++) begin
            pipe_wd = 32'h100 + c;
            #1;
            n_cmp++;
            if (ll_ready !== 0 || pipe_ready !== 1) begin
                n_err++;
                $display("FAIL contention_refuse c%0d: ll_ready=%b pipe_ready=%b, required 0/1", c, ll_ready, pipe_ready);
            end
            exp_q.push_back(rf_wr_t'{5'd3, pipe_wd});
            @(negedge clk);
        end
        #1;
        n_cmp++;
        if (pipe_ready !== 0 || ll_ready !== 1) begin
            n_err++;
            $display("FAIL contention_force: pipe_ready=%b ll_ready=%b, required 0/1", pipe_ready, ll_ready);
        end
        exp_q.push_back(rf_wr_t'{5'd7, 32'h1234});
        @(negedge clk);
        ll_valid = 0; pipe_wd = 32'h200;
        #1;
        n_cmp++;
        if (pipe_ready !== 1) begin
            n_err++;
            $display("FAIL contention_release: pipe_ready=%b, required 1", pipe_ready);
        end
        exp_q.push_back(rf_wr_t'{5'd3, 32'h200});
        @(negedge clk);
        pipe_valid = 0;
        @(negedge clk);
    endtask

    // Partial starvation, then an idle-gap grant; the following contention must start counting from 0.
    task automatic test_idle_gap();
        pipe_valid = 1; pipe_rd = 4; ll_valid = 1; ll_rd = 11; ll_wd = 32'hABC;
        for (int c = 1; c <= 2; c++) begin
            pipe_wd = 32'h300 + c;
            exp_q.push_back(rf_wr_t'{5'd4, pipe_wd});
            @(negedge clk);
        end
        pipe_valid = 0;
        #1;
        n_cmp++;
        if (ll_ready !== 1) begin
            n_err++;
            $display("FAIL idle_gap_grant: ll_ready=%b, required 1", ll_ready);
        end
        exp_q.push_back(rf_wr_t'{5'd11, 32'hABC});
        @(negedge clk);
        ll_valid = 0;
        @(negedge clk);
        test_contention();
    endtask

    task automatic test_scoreboard();
        rsv_valid = 1; rsv_rd = 9;
        @(negedge clk);
        rsv_valid = 0;
        #1;
        n_cmp++;
        if (busy_mask !== 32'h200) begin
            n_err++;
            $display("FAIL sb_reserve: busy=%h, required 00000200", busy_mask);
        end
        hz_rs1 = 9;
        #1;
        n_cmp++;
        if (hz_stall !== 1) begin
            n_err++;
            $display("FAIL sb_stall_rs1: hz_stall=%b, required 1", hz_stall);
        end
        hz_rs1 = 0; hz_rs2 = 9;
        #1;
        n_cmp++;
        if (hz_stall !== 1) begin
            n_err++;
            $display("FAIL sb_stall_rs2: hz_stall=%b, required 1", hz_stall);
        end
        hz_rs2 = 0;
        @(negedge clk);
        ll_valid = 1; ll_rd = 9; ll_wd = 32'h55; hz_rs1 = 9;
        #1;
        n_cmp++;
        if (ll_ready !== 1 || hz_stall !== 1) begin
            n_err++;
            $display("FAIL sb_no_bypass: ll_ready=%b hz_stall=%b, required 1/1", ll_ready, hz_stall);
        end
        exp_q.push_back(rf_wr_t'{5'd9, 32'h55});
        @(negedge clk);
        ll_valid = 0;
        #1;
        n_cmp++;
        if (busy_mask !== 0 || hz_stall !== 0) begin
            n_err++;
            $display("FAIL sb_clear: busy=%h hz_stall=%b, required 0/0", busy_mask, hz_stall);
        end
        rsv_valid = 1; rsv_rd = 9;
        @(negedge clk);
        ll_valid = 1; ll_rd = 9; ll_wd = 32'h66;
        exp_q.push_back(rf_wr_t'{5'd9, 32'h66});
        @(negedge clk);
        rsv_valid = 0; ll_valid = 0;
        #1;
        n_cmp++;
        if (busy_mask !== 32'h200) begin
            n_err++;
            $display("FAIL sb_set_wins: busy=%h, required 00000200", busy_mask);
        end
        ll_valid = 1; ll_rd = 9; ll_wd = 32'h77;
        exp_q.push_back(rf_wr_t'{5'd9, 32'h77});
        @(negedge clk);
        ll_valid = 0; hz_rs1 = 0;
        #1;
        n_cmp++;
        if (busy_mask !== 0) begin
            n_err++;
            $display("FAIL sb_final_clear: busy=%h, required 0", busy_mask);
        end
        @(negedge clk);
    endtask

    task automatic test_x0();
        pipe_valid = 1; pipe_rd = 0; pipe_wd = 32'hFFFF_FFFF;
        #1;
        n_cmp++;
        if (pipe_ready !== 1) begin
            n_err++;
            $display("FAIL x0_pipe_ready: pipe_ready=%b, required 1", pipe_ready);
        end
        @(negedge clk);
        pipe_valid = 0;
        #1;
        n_cmp++;
        if (rf_we !== 0) begin
            n_err++;
            $display("FAIL x0_no_we: rf_we=%b, required 0", rf_we);
        end
        rsv_valid = 1; rsv_rd = 0;
        @(negedge clk);
        rsv_valid = 0;
        #1;
        n_cmp++;
        if (busy_mask !== 0) begin
            n_err++;
            $display("FAIL x0_reserve: busy=%h, required 0", busy_mask);
        end
        hz_rs1 = 0; hz_rs2 = 0;
        #1;
        n_cmp++;
        if (hz_stall !== 0) begin
            n_err++;
            $display("FAIL x0_stall: hz_stall=%b, required 0", hz_stall);
        end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        rsv_valid = 1; rsv_rd = 7;
        @(negedge clk);
        rsv_valid = 0;
        pipe_valid = 1; pipe_rd = 2; ll_valid = 1; ll_rd = 5; ll_wd = 32'h99;
        for (int c = 1; c <= STARVE_LIMIT; c++) begin
            pipe_wd = 32'h400 + c;
            exp_q.push_back(rf_wr_t'{5'd2, pipe_wd});
            @(negedge clk);
        end
        #1;
        n_cmp++;
        if (pipe_ready !== 0 || rf_we !== 1 || busy_mask !== 32'h80) begin
            n_err++;
            $display("FAIL rst_pre: pipe_ready=%b rf_we=%b busy=%h, required 0/1/00000080", pipe_ready, rf_we, busy_mask);
        end
        #1;
        rst_n = 0;
        #1;
        n_cmp++;
        if (rf_we !== 0 || busy_mask !== 0) begin
            n_err++;
            $display("FAIL rst_async: rf_we=%b busy=%h, required 0/0", rf_we, busy_mask);
        end
        exp_q.delete();
        idle_inputs();
        @(negedge clk); @(negedge clk);
        rst_n = 1;
        #1;
        n_cmp++;
        if (pipe_ready !== 1) begin
            n_err++;
            $display("FAIL rst_release_pipe: pipe_ready=%b, required 1", pipe_ready);
        end
        pipe_valid = 1; pipe_rd = 0;
        #1;
        n_cmp++;
        if (ll_ready !== 0) begin
            n_err++;
            $display("FAIL rst_release_state: ll_ready=%b, required 0", ll_ready);
        end
        @(negedge clk);
        pipe_valid = 0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        @(negedge clk);
        test_pipe_only();
        test_contention();
        test_idle_gap();
        test_scoreboard();
        test_x0();
        test_async_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if (exp_q.size() !== 0) begin
            n_err++;
            $display("FAIL queue_drain: %0d writes outstanding, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
